// File: rtl/id_stage_scoreboard_if.sv
// Fetch / decode / EX / writeback bundle around the ID stage.
// Master side is the surrounding pipeline, slave side is the ID stage.
interface id_stage_scoreboard_if #(
    parameter int WORD_W = 16,
    parameter int RA_W   = 2
);
    logic              if_valid;
    logic [WORD_W-1:0] if_pc;
    logic [WORD_W-1:0] if_inst;
    logic              if_ready;
    logic              flush;
    logic              dec_use_rs;
    logic              dec_use_rt;
    logic              dec_reg_write;
    logic [RA_W-1:0]   dec_dest;
    logic              dec_halt;
    logic [WORD_W-1:0] id_inst;
    logic [WORD_W-1:0] id_pc;
    logic [RA_W-1:0]   rs;
    logic [RA_W-1:0]   rt;
    logic [RA_W-1:0]   rd;
    logic [WORD_W-1:0] rdata1;
    logic [WORD_W-1:0] rdata2;
    logic [WORD_W-1:0] imm_ext;
    logic [WORD_W-1:0] branch_target;
    logic [WORD_W-1:0] jump_target;
    logic              ex_valid;
    logic              ex_ready;
    logic              stall;
    logic              wb_we;
    logic [RA_W-1:0]   wb_addr;
    logic [WORD_W-1:0] wb_data;
    logic              halted;

    modport master (
        output if_valid, if_pc, if_inst, flush,
        output dec_use_rs, dec_use_rt, dec_reg_write,
        output dec_dest, dec_halt, ex_ready,
        output wb_we, wb_addr, wb_data,
        input  if_ready, id_inst, id_pc, rs, rt, rd,
        input  rdata1, rdata2, imm_ext,
        input  branch_target, jump_target,
        input  ex_valid, stall, halted
    );

    modport slave (
        input  if_valid, if_pc, if_inst, flush,
        input  dec_use_rs, dec_use_rt, dec_reg_write,
        input  dec_dest, dec_halt, ex_ready,
        input  wb_we, wb_addr, wb_data,
        output if_ready, id_inst, id_pc, rs, rt, rd,
        output rdata1, rdata2, imm_ext,
        output branch_target, jump_target,
        output ex_valid, stall, halted
    );
endinterface

// File: rtl/id_stage_scoreboard.sv
// ID stage: IF/ID latch, bypassed register file and a per-register
// pending-write scoreboard that holds RAW and saturation hazards.
module id_stage_scoreboard #(
    parameter int WORD_W   = 16,
    parameter int RA_W     = 2,
    parameter int IMM_W    = 8,
    parameter int CNT_W    = 2,
    parameter int ZERO_REG = 0
) (
    input logic clk,
    input logic reset_n,
    id_stage_scoreboard_if.slave bus
);
    localparam int REG_CNT = 1 << RA_W;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic              r_valid;
    logic [WORD_W-1:0] r_pc;
    logic [WORD_W-1:0] r_inst;
    logic              r_halted;
    logic [WORD_W-1:0] r_regs [REG_CNT];
    logic [CNT_W-1:0]  r_cnt  [REG_CNT];

    logic [RA_W-1:0]   w_rs;
    logic [RA_W-1:0]   w_rt;
    logic [RA_W-1:0]   w_rd;
    logic [WORD_W-1:0] w_imm;
    logic              w_busy_rs;
    logic              w_busy_rt;
    logic              w_sat;
    logic              w_hazard;
    logic              w_ex_valid;
    logic              w_issue;
    logic              w_if_ready;
    logic              w_capture;
    logic              w_rs_zero;
    logic              w_rt_zero;
    logic              w_wb_ok;
    logic [REG_CNT-1:0] w_inc;
    logic [REG_CNT-1:0] w_dec;

    assign w_rs  = r_inst[WORD_W-5 -: RA_W];
    assign w_rt  = r_inst[WORD_W-5-RA_W -: RA_W];
    assign w_rd  = r_inst[WORD_W-5-2*RA_W -: RA_W];
    assign w_imm = {{(WORD_W-IMM_W){r_inst[IMM_W-1]}},
                    r_inst[IMM_W-1:0]};

    // A last pending write landing this cycle is served by the bypass.
    assign w_busy_rs = (r_cnt[w_rs] != '0)
        & ~((r_cnt[w_rs] == CNT_ONE) & bus.wb_we
            & (bus.wb_addr == w_rs));
    assign w_busy_rt = (r_cnt[w_rt] != '0)
        & ~((r_cnt[w_rt] == CNT_ONE) & bus.wb_we
            & (bus.wb_addr == w_rt));
    assign w_sat = r_cnt[bus.dec_dest] == CNT_MAX;

    assign w_hazard = r_valid
        & ((bus.dec_use_rs & w_busy_rs)
        | (bus.dec_use_rt & w_busy_rt)
        | (bus.dec_reg_write & w_sat));

    assign w_ex_valid = r_valid & ~w_hazard & ~bus.flush & ~r_halted;
    assign w_issue    = w_ex_valid & bus.ex_ready;
    assign w_if_ready = ~r_halted & ~bus.flush & (~r_valid | w_issue);
    assign w_capture  = bus.if_valid & w_if_ready;

    assign w_rs_zero = (ZERO_REG != 0) && (w_rs == '0);
    assign w_rt_zero = (ZERO_REG != 0) && (w_rt == '0);
    assign w_wb_ok   = bus.wb_we
        & ~((ZERO_REG != 0) && (bus.wb_addr == '0));

    assign bus.if_ready      = w_if_ready;
    assign bus.ex_valid      = w_ex_valid;
    assign bus.stall         = w_hazard & ~bus.flush;
    assign bus.halted        = r_halted;
    assign bus.id_inst       = r_inst;
    assign bus.id_pc         = r_pc;
    assign bus.rs            = w_rs;
    assign bus.rt            = w_rt;
    assign bus.rd            = w_rd;
    assign bus.imm_ext       = w_imm;
    assign bus.branch_target = r_pc + w_imm;
    assign bus.jump_target   = {r_pc[WORD_W-1 -: 4],
                                r_inst[WORD_W-5:0]};
    assign bus.rdata1 = w_rs_zero ? '0
        : (bus.wb_we && bus.wb_addr == w_rs) ? bus.wb_data
        : r_regs[w_rs];
    assign bus.rdata2 = w_rt_zero ? '0
        : (bus.wb_we && bus.wb_addr == w_rt) ? bus.wb_data
        : r_regs[w_rt];

    // Per-register increment on issue, decrement on writeback.
    always_comb begin
        w_inc = '0;
        w_dec = '0;
        for (int i = 0; i < REG_CNT; i++) begin
            w_inc[i] = w_issue & bus.dec_reg_write
                & (bus.dec_dest == RA_W'(i))
                & ~((ZERO_REG != 0) && (i == 0));
            w_dec[i] = bus.wb_we & (bus.wb_addr == RA_W'(i))
                & (r_cnt[i] != '0);
        end
    end

    // IF/ID latch: flush beats capture, capture beats plain issue.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid <= 1'b0;
            r_pc    <= '0;
            r_inst  <= '0;
        end else if (bus.flush) begin
            r_valid <= 1'b0;
        end else if (w_capture) begin
            r_valid <= 1'b1;
            r_pc    <= bus.if_pc;
            r_inst  <= bus.if_inst;
        end else if (w_issue) begin
            r_valid <= 1'b0;
        end
    end

    // Sticky halt once a HLT leaves for EX.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_halted <= 1'b0;
        else if (w_issue && bus.dec_halt) r_halted <= 1'b1;
    end

    // Register file write port; keeps running while halted.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_CNT; i++) r_regs[i] <= '0;
        end else if (w_wb_ok) begin
            r_regs[bus.wb_addr] <= bus.wb_data;
        end
    end

    // Pending-write counters; simultaneous inc and dec cancel.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < REG_CNT; i++) r_cnt[i] <= '0;
        end else begin
            for (int i = 0; i < REG_CNT; i++) begin
                if (w_inc[i] && !w_dec[i])
                    r_cnt[i] <= r_cnt[i] + CNT_ONE;
                else if (w_dec[i] && !w_inc[i])
                    r_cnt[i] <= r_cnt[i] - CNT_ONE;
            end
        end
    end
endmodule

// File: tb/tb_id_stage_scoreboard.sv
// Bench for id_stage_scoreboard: directed scenarios plus random traffic,
// checked by a monitor against a queue-and-array reference model.
module tb_id_stage_scoreboard;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    id_stage_scoreboard_if #(.WORD_W(16), .RA_W(2)) bus ();

    id_stage_scoreboard #(
        .WORD_W(16), .RA_W(2), .IMM_W(8), .CNT_W(2), .ZERO_REG(0)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .bus(bus)
    );

    typedef struct packed {
        logic use_rs;
        logic use_rt;
        logic wr;
        logic halt;
        logic [1:0] dest;
    } dec_t;

    typedef struct packed {
        logic [15:0] pc;
        logic [15:0] inst;
        logic [15:0] imm;
        logic [15:0] br;
        logic [15:0] jmp;
        logic [1:0]  rs;
        logic [1:0]  rt;
        logic [1:0]  rd;
    } exp_t;

    // Toy control decoder: opcode = inst[15:12], F is HLT.
    function automatic dec_t decode(input logic [15:0] inst);
        dec_t d;
        logic [3:0] op;
        op       = inst[15:12];
        d.halt   = (op == 4'hF);
        d.use_rs = op[2];
        d.use_rt = op[0];
        d.wr     = op[3] & ~d.halt;
        d.dest   = inst[7:6];
        return d;
    endfunction

    dec_t dut_dec;
    assign dut_dec           = decode(bus.id_inst);
    assign bus.dec_use_rs    = dut_dec.use_rs;
    assign bus.dec_use_rt    = dut_dec.use_rt;
    assign bus.dec_reg_write = dut_dec.wr;
    assign bus.dec_dest      = dut_dec.dest;
    assign bus.dec_halt      = dut_dec.halt;

    exp_t        q[$];
    int          m_cnt[4];
    logic [15:0] m_regs[4];
    bit          m_halted;
    bit          rst_active = 1'b1;
    int          n_cmp = 0;
    int          n_fail = 0;

    task automatic chk(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     name, act, exp, $time);
        end
    endtask

    function automatic exp_t mk(input logic [15:0] pc,
                                input logic [15:0] inst);
        exp_t e;
        int imm;
        imm = int'(inst & 16'h00FF);
        if (imm >= 128) imm -= 256;
        e.pc   = pc;
        e.inst = inst;
        e.imm  = 16'(imm);
        e.br   = 16'(int'(pc) + imm);
        e.jmp  = (pc & 16'hF000) | (inst & 16'h0FFF);
        e.rs   = 2'(inst >> 10);
        e.rt   = 2'(inst >> 8);
        e.rd   = 2'(inst >> 6);
        return e;
    endfunction

    task automatic model_reset();
        q.delete();
        for (int i = 0; i < 4; i++) begin
            m_cnt[i]  = 0;
            m_regs[i] = 16'h0;
        end
        m_halted = 1'b0;
    endtask

    function automatic bit busy(input logic [1:0] r, input bit wbv);
        if (m_cnt[r] == 0) return 1'b0;
        if (m_cnt[r] == 1 && wbv && bus.wb_addr == r) return 1'b0;
        return 1'b1;
    endfunction

    task automatic monitor_step();
        bit idv, hz, exv, iss, rdy, wbv, fl;
        dec_t d;
        exp_t h;
        logic [15:0] v1, v2;
        idv = q.size() != 0;
        wbv = bus.wb_we === 1'b1;
        fl  = bus.flush === 1'b1;
        d = '0;
        h = '0;
        if (idv) begin
            h = q[0];
            d = decode(h.inst);
        end
        hz = idv && ((d.use_rs && busy(h.rs, wbv))
                  || (d.use_rt && busy(h.rt, wbv))
                  || (d.wr && m_cnt[d.dest] == 3));
        exv = idv && !hz && !fl && !m_halted;
        iss = exv && (bus.ex_ready === 1'b1);
        rdy = !m_halted && !fl && (!idv || iss);
        chk("ex_valid", 32'(bus.ex_valid), 32'(exv));
        chk("stall", 32'(bus.stall), 32'(hz && !fl));
        chk("if_ready", 32'(bus.if_ready), 32'(rdy));
        chk("halted", 32'(bus.halted), 32'(m_halted));
        if (idv) begin
            chk("id_pc", 32'(bus.id_pc), 32'(h.pc));
            chk("id_inst", 32'(bus.id_inst), 32'(h.inst));
            chk("rs", 32'(bus.rs), 32'(h.rs));
            chk("rt", 32'(bus.rt), 32'(h.rt));
            chk("rd", 32'(bus.rd), 32'(h.rd));
            chk("imm_ext", 32'(bus.imm_ext), 32'(h.imm));
            chk("branch", 32'(bus.branch_target), 32'(h.br));
            chk("jump", 32'(bus.jump_target), 32'(h.jmp));
            v1 = (wbv && bus.wb_addr == h.rs) ? bus.wb_data
                                              : m_regs[h.rs];
            v2 = (wbv && bus.wb_addr == h.rt) ? bus.wb_data
                                              : m_regs[h.rt];
            chk("rdata1", 32'(bus.rdata1), 32'(v1));
            chk("rdata2", 32'(bus.rdata2), 32'(v2));
        end
        if (wbv) begin
            m_regs[bus.wb_addr] = bus.wb_data;
            if (m_cnt[bus.wb_addr] > 0) m_cnt[bus.wb_addr]--;
        end
        if (iss && d.wr) m_cnt[d.dest]++;
        if (iss && d.halt) m_halted = 1'b1;
        if (fl) q.delete();
        else if (iss) void'(q.pop_front());
    endtask

    // Checker: sample settled outputs mid-cycle, then advance the model.
    always @(negedge clk) begin
        #2;
        if (!rst_active) monitor_step();
    end

    // Record each accepted fetch offer as the expected ID contents.
    always @(negedge clk) begin
        #3;
        if (!rst_active && bus.if_valid === 1'b1
            && bus.if_ready === 1'b1)
            q.push_back(mk(bus.if_pc, bus.if_inst));
    end

    task automatic drive(input bit v, input logic [15:0] pc,
                         input logic [15:0] inst, input bit fl,
                         input bit er, input bit we,
                         input logic [1:0] wa, input logic [15:0] wd);
        @(negedge clk);
        bus.if_valid = v;
        bus.if_pc    = pc;
        bus.if_inst  = inst;
        bus.flush    = fl;
        bus.ex_ready = er;
        bus.wb_we    = we;
        bus.wb_addr  = wa;
        bus.wb_data  = wd;
    endtask

    task automatic offer(input logic [15:0] inst, input bit er);
        drive(1'b1, 16'h0100, inst, 1'b0, er, 1'b0, 2'd0, 16'h0);
    endtask

    task automatic idle(input bit er);
        drive(1'b0, 16'h0, 16'h0, 1'b0, er, 1'b0, 2'd0, 16'h0);
    endtask

    task automatic wb(input logic [1:0] r, input logic [15:0] d);
        drive(1'b0, 16'h0, 16'h0, 1'b0, 1'b1, 1'b1, r, d);
    endtask

    task automatic drain();
        logic [1:0] r;
        bit any;
        drive(1'b0, 16'h0, 16'h0, 1'b1, 1'b1, 1'b0, 2'd0, 16'h0);
        for (int k = 0; k < 40; k++) begin
            any = 1'b0;
            for (int i = 0; i < 4; i++)
                if (!any && m_cnt[i] > 0) begin
                    r = 2'(i);
                    any = 1'b1;
                end
            if (!any) break;
            wb(r, 16'($urandom));
        end
    endtask

    initial begin
        bus.if_valid = 1'b0;
        bus.if_pc    = 16'h0;
        bus.if_inst  = 16'h0;
        bus.flush    = 1'b0;
        bus.ex_ready = 1'b0;
        bus.wb_we    = 1'b0;
        bus.wb_addr  = 2'd0;
        bus.wb_data  = 16'h0;
        model_reset();
        repeat (2) @(negedge clk);
        reset_n    = 1'b1;
        rst_active = 1'b0;

        idle(1'b1);
        #2;
        chk("rst ex_valid", 32'(bus.ex_valid), 32'd0);
        chk("rst stall", 32'(bus.stall), 32'd0);
        chk("rst if_ready", 32'(bus.if_ready), 32'd1);
        chk("rst id_pc", 32'(bus.id_pc), 32'd0);
        chk("rst id_inst", 32'(bus.id_inst), 32'd0);
        chk("rst halted", 32'(bus.halted), 32'd0);

        drive(1'b1, 16'h0011, 16'h6A85, 1'b0, 1'b1,
              1'b0, 2'd0, 16'h0);
        idle(1'b0);
        #2;
        chk("t1 ex_valid", 32'(bus.ex_valid), 32'd1);
        chk("t1 rs", 32'(bus.rs), 32'd2);
        chk("t1 rt", 32'(bus.rt), 32'd2);
        chk("t1 rd", 32'(bus.rd), 32'd2);
        chk("t1 imm", 32'(bus.imm_ext), 32'hFF85);
        chk("t1 branch", 32'(bus.branch_target), 32'hFF96);
        idle(1'b1);

        offer(16'h8040, 1'b1);
        offer(16'h4400, 1'b1);
        for (int k = 0; k < 3; k++) begin
            offer(16'h0000, 1'b1);
            #2;
            chk("raw stall", 32'(bus.stall), 32'd1);
            chk("raw if_ready", 32'(bus.if_ready), 32'd0);
        end
        wb(2'd1, 16'h1234);
        #2;
        chk("bypass issue", 32'(bus.ex_valid), 32'd1);
        chk("bypass rdata1", 32'(bus.rdata1), 32'h1234);
        offer(16'h4400, 1'b1);
        idle(1'b0);
        #2;
        chk("cnt1 clear", 32'(bus.stall), 32'd0);
        idle(1'b1);

        offer(16'h8080, 1'b1);
        idle(1'b1);
        offer(16'h8080, 1'b1);
        wb(2'd2, 16'h5555);
        offer(16'h4800, 1'b1);
        idle(1'b1);
        #2;
        chk("cnt2 held", 32'(bus.stall), 32'd1);
        wb(2'd2, 16'h7777);
        #2;
        chk("cnt2 issue", 32'(bus.ex_valid), 32'd1);
        chk("cnt2 rdata1", 32'(bus.rdata1), 32'h7777);

        for (int k = 0; k < 4; k++) offer(16'h80C0, 1'b1);
        idle(1'b1);
        #2;
        chk("sat stall", 32'(bus.stall), 32'd1);
        wb(2'd3, 16'h3333);
        #2;
        chk("sat stall wb", 32'(bus.stall), 32'd1);
        idle(1'b1);
        #2;
        chk("sat release", 32'(bus.ex_valid), 32'd1);

        offer(16'h80C0, 1'b1);
        idle(1'b1);
        #2;
        chk("fl stalled", 32'(bus.stall), 32'd1);
        drive(1'b1, 16'h0200, 16'h1234, 1'b1, 1'b1,
              1'b0, 2'd0, 16'h0);
        #2;
        chk("fl stall", 32'(bus.stall), 32'd0);
        chk("fl if_ready", 32'(bus.if_ready), 32'd0);
        chk("fl ex_valid", 32'(bus.ex_valid), 32'd0);
        idle(1'b0);
        #2;
        chk("fl empty", 32'(bus.ex_valid), 32'd0);
        chk("fl ready", 32'(bus.if_ready), 32'd1);
        chk("fl no capture", 32'(bus.id_inst), 32'h80C0);
        offer(16'h80C0, 1'b1);
        idle(1'b1);
        #2;
        chk("fl cnt kept", 32'(bus.stall), 32'd1);
        drain();

        for (int n = 0; n < 600; n++) begin
            logic [15:0] inst;
            logic [1:0] r;
            bit we;
            inst = {4'($urandom_range(14)), 12'($urandom)};
            we = 1'b0;
            r = 2'd0;
            if ($urandom_range(99) < 35)
                for (int k = 0; k < 8; k++) begin
                    logic [1:0] c;
                    c = 2'($urandom_range(3));
                    if (!we && m_cnt[c] > 0) begin
                        r = c;
                        we = 1'b1;
                    end
                end
            drive($urandom_range(99) < 70, 16'($urandom), inst,
                  $urandom_range(99) < 5, $urandom_range(99) < 80,
                  we, r, 16'($urandom));
        end
        drain();

        offer(16'h8040, 1'b1);
        offer(16'hF000, 1'b1);
        offer(16'h4400, 1'b1);
        offer(16'h6A85, 1'b1);
        #2;
        chk("hlt halted", 32'(bus.halted), 32'd1);
        chk("hlt if_ready", 32'(bus.if_ready), 32'd0);
        chk("hlt ex_valid", 32'(bus.ex_valid), 32'd0);
        wb(2'd1, 16'hBEEF);
        idle(1'b1);
        #2;
        chk("hlt wb reg", 32'(bus.rdata1), 32'hBEEF);
        chk("hlt no issue", 32'(bus.ex_valid), 32'd0);
        #1;
        rst_active = 1'b1;
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("async halted", 32'(bus.halted), 32'd0);
        chk("async if_ready", 32'(bus.if_ready), 32'd1);
        chk("async ex_valid", 32'(bus.ex_valid), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        rst_active = 1'b0;
        idle(1'b1);
        #2;
        chk("post rst regs", 32'(bus.rdata1), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end
endmodule
